// File: rtl/mem_arb_pkg.sv
// Shared state encoding and default sizing for the fetch/data memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_AW             = 32;
  localparam int unsigned DEF_DW             = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_WAIT = 2'd1,
    I_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester and memory-port signals around the arbiter.
// master = arbiter view, slave = pipeline/memory view.
interface mem_port_arbiter_if import mem_arb_pkg::*; #(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
);

  logic          ireq;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] irdata;
  logic          ivalid;

  logic          dreq;
  logic          dwe;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dwdata;
  logic [DW-1:0] drdata;
  logic          dvalid;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  logic          stall_f;
  logic          stall_m;
  logic          err;

  modport master (
    input  ireq, iaddr, dreq, dwe, daddr, dwdata, mem_rdata, mem_ack,
    output irdata, ivalid, drdata, dvalid,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output stall_f, stall_m, err
  );

  modport slave (
    output ireq, iaddr, dreq, dwe, daddr, dwdata, mem_rdata, mem_ack,
    input  irdata, ivalid, drdata, dvalid,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  stall_f, stall_m, err
  );

endinterface

// File: rtl/arb_timeout_ctr.sv
// Wait-cycle counter for the arbiter; expired is high in the LIMIT-th wait cycle.
// Only instantiated when MEMARB_TIMEOUT_EN is defined.
module arb_timeout_ctr import mem_arb_pkg::*; #(
  parameter int unsigned LIMIT = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [CW-1:0] cnt;

  // cnt is 0 in the first wait cycle, so LIMIT-1 marks the LIMIT-th one.
  assign expired = (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Optional wait timeout enabled by defining MEMARB_TIMEOUT_EN.
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int unsigned AW             = DEF_AW,
  parameter int unsigned DW             = DEF_DW,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus
);

  state_t        state, state_n;
  logic          last_d, last_d_n;
  logic          mem_req_q, mem_req_n;
  logic          mem_we_q, mem_we_n;
  logic [AW-1:0] mem_addr_q, mem_addr_n;
  logic [DW-1:0] mem_wdata_q, mem_wdata_n;
  logic [DW-1:0] irdata_q, irdata_n;
  logic [DW-1:0] drdata_q, drdata_n;
  logic          ivalid_q, ivalid_n;
  logic          dvalid_q, dvalid_n;
  logic          err_q, err_n;
  logic          idle_free, grant_d, grant_i, waiting, timeout_hit, stall_m;

  // The cycle carrying a valid pulse never grants, so a requester that still
  // holds its req for that cycle is not served twice.
  assign idle_free = (state == IDLE) && !ivalid_q && !dvalid_q;
  assign grant_d   = idle_free && bus.dreq && (!bus.ireq || !last_d);
  assign grant_i   = idle_free && bus.ireq && !grant_d;
  assign waiting   = (state == D_WAIT) || (state == I_WAIT);

`ifdef MEMARB_TIMEOUT_EN
  arb_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout_ctr (
    .clk     (clk),
    .reset   (reset),
    .clr     (grant_d || grant_i),
    .en      (waiting),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_n     = state;
    last_d_n    = last_d;
    mem_req_n   = mem_req_q;
    mem_we_n    = mem_we_q;
    mem_addr_n  = mem_addr_q;
    mem_wdata_n = mem_wdata_q;
    irdata_n    = irdata_q;
    drdata_n    = drdata_q;
    ivalid_n    = 1'b0;
    dvalid_n    = 1'b0;
    err_n       = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_d || grant_i) begin
          state_n    = grant_d ? D_WAIT : I_WAIT;
          last_d_n   = grant_d;
          mem_req_n  = 1'b1;
          mem_we_n   = grant_d && bus.dwe;
          mem_addr_n = grant_d ? bus.daddr : bus.iaddr;
          if (grant_d) mem_wdata_n = bus.dwdata;
        end
      end
      D_WAIT, I_WAIT: begin
        if (waiting && (bus.mem_ack || timeout_hit)) begin
          state_n   = IDLE;
          mem_req_n = 1'b0;
          err_n     = !bus.mem_ack;
          if (state == D_WAIT) begin
            dvalid_n = 1'b1;
            drdata_n = bus.mem_ack ? bus.mem_rdata : '0;
          end else if (bus.ireq) begin
            // A fetch dropped before completion (flush) finishes silently.
            ivalid_n = 1'b1;
            irdata_n = bus.mem_ack ? bus.mem_rdata : '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: all of these are control or bus registers, so all are reset; there is no storage array to exempt.
      state       <= IDLE;
      last_d      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      irdata_q    <= '0;
      drdata_q    <= '0;
      ivalid_q    <= 1'b0;
      dvalid_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_n;
      last_d      <= last_d_n;
      mem_req_q   <= mem_req_n;
      mem_we_q    <= mem_we_n;
      mem_addr_q  <= mem_addr_n;
      mem_wdata_q <= mem_wdata_n;
      irdata_q    <= irdata_n;
      drdata_q    <= drdata_n;
      ivalid_q    <= ivalid_n;
      dvalid_q    <= dvalid_n;
      err_q       <= err_n;
    end
  end

  assign stall_m       = !reset && bus.dreq && !dvalid_q;
  assign bus.stall_m   = stall_m;
  assign bus.stall_f   = stall_m || (!reset && bus.ireq && !ivalid_q);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.irdata    = irdata_q;
  assign bus.drdata    = drdata_q;
  assign bus.ivalid    = ivalid_q;
  assign bus.dvalid    = dvalid_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, scoreboard queues,
// a latency-programmable memory responder and hand-written corner sequences.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp_rdata;
    int          exp_n;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gnt_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  gnt_t        grant_log[$];
  logic [31:0] mem_img [logic [31:0]];

  int ack_lat   = 1;
  bit no_ack    = 0;
  bit stray_ack = 0;
  bit exp_err   = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: acks in the ack_lat-th wait cycle and checks the port stays put.
  int   wcnt = 0;
  gnt_t cur_g;
  always @(negedge clk) begin
    if (reset || !bus.mem_req) begin
      bus.mem_ack   = stray_ack;
      bus.mem_rdata = 32'h0;
      wcnt          = 0;
    end else begin
      wcnt++;
      if (wcnt == 1) begin
        cur_g = '{we: bus.mem_we, addr: bus.mem_addr, wdata: bus.mem_wdata};
        grant_log.push_back(cur_g);
      end else begin
        check("mem_port_hold", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, cur_g);
      end
      if (!no_ack && wcnt == ack_lat) begin
        bus.mem_ack = 1'b1;
        if (bus.mem_we) begin
          mem_img[bus.mem_addr] = bus.mem_wdata;
          bus.mem_rdata = 32'h0;
        end else begin
          bus.mem_rdata = mem_img.exists(bus.mem_addr) ? mem_img[bus.mem_addr] : ~bus.mem_addr;
        end
      end else begin
        bus.mem_ack = 1'b0;
      end
    end
  end

  // Scoreboard side: every valid pulse pops and compares the expected data.
  bit prev_dv = 0;
  bit prev_iv = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.dvalid) begin
        check("dvalid_single_pulse", prev_dv, 0);
        check("dvalid_expected", exp_d.size() > 0, 1);
        if (exp_d.size() > 0) check("drdata", bus.drdata, exp_d.pop_front());
        check("err_on_dvalid", bus.err, exp_err);
      end
      if (bus.ivalid) begin
        check("ivalid_single_pulse", prev_iv, 0);
        check("ivalid_expected", exp_i.size() > 0, 1);
        if (exp_i.size() > 0) check("irdata", bus.irdata, exp_i.pop_front());
        check("err_on_ivalid", bus.err, exp_err);
      end
      if (bus.err) check("err_with_valid", bus.dvalid | bus.ivalid, 1);
      prev_dv = bus.dvalid;
      prev_iv = bus.ivalid;
    end
  end

  // Raise one request, wait for its valid pulse (bounded), keep or drop req after.
  task automatic txn(input bit is_d, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp,
                     input bit keep, output int n);
    bit seen;
    n = 0;
    seen = 0;
    if (is_d) begin
      bus.dreq = 1'b1; bus.dwe = we; bus.daddr = addr; bus.dwdata = wdata;
      exp_d.push_back(exp);
    end else begin
      bus.ireq = 1'b1; bus.iaddr = addr;
      exp_i.push_back(exp);
    end
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      seen = is_d ? bus.dvalid : bus.ivalid;
      if (!seen) begin
        if (is_d) check("stall_m_wait", bus.stall_m, 1);
        else      check("stall_f_wait", bus.stall_f, 1);
      end
    end
    check("valid_seen", seen, 1);
    if (is_d)          check("stall_m_release", bus.stall_m, 0);
    else if (!bus.dreq) check("stall_f_release", bus.stall_f, 0);
    @(negedge clk);
    if (!keep) begin
      if (is_d) bus.dreq = 1'b0;
      else      bus.ireq = 1'b0;
    end
  endtask

  vec_t        vecs[7];
  logic [32:0] order_exp[4];
  int          n;
  gnt_t        g;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.ireq = 0; bus.iaddr = '0;
    bus.dreq = 0; bus.dwe = 0; bus.daddr = '0; bus.dwdata = '0;

    vecs[0] = '{0, 0, 32'h0000_0004, 32'h0,         1, 32'h00A0_0093, 2};
    vecs[1] = '{1, 0, 32'h0000_0200, 32'h0,         5, 32'h1234_5678, 6};
    vecs[2] = '{1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 2, 32'h0,         3};
    vecs[3] = '{1, 0, 32'h0000_0100, 32'h0,         1, 32'hDEAD_BEEF, 2};
    vecs[4] = '{0, 0, 32'hFFFF_FFFC, 32'h0,         1, 32'h0000_006F, 2};
    vecs[5] = '{1, 0, 32'h0000_0000, 32'h0,         3, 32'hFFFF_FFFF, 4};
    vecs[6] = '{0, 0, 32'h0000_0008, 32'h0,         2, 32'h0010_0113, 3};
    for (int k = 0; k < 7; k++)
      if (!vecs[k].we) mem_img[vecs[k].addr] = vecs[k].exp_rdata;
    mem_img[32'h10]  = 32'h0000_0013;
    mem_img[32'h14]  = 32'h0020_8133;
    mem_img[32'h104] = 32'hCAFE_F00D;
    order_exp[0] = {1'b1, 32'h100};
    order_exp[1] = {1'b0, 32'h10};
    order_exp[2] = {1'b0, 32'h104};
    order_exp[3] = {1'b0, 32'h14};

    // Reset values
    @(negedge clk);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_irdata", bus.irdata, 0);
    check("rst_drdata", bus.drdata, 0);
    check("rst_valids_err", {bus.ivalid, bus.dvalid, bus.err}, 0);
    check("rst_state", dut.state, IDLE);
    reset = 1'b0;

    // Reset in the middle of a data wait
    no_ack = 1;
    bus.dreq = 1; bus.dwe = 0; bus.daddr = 32'h40;
    repeat (2) @(negedge clk);
    check("pre_rst_mem_req", bus.mem_req, 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_mem_req", bus.mem_req, 0);
    check("midrst_dvalid", bus.dvalid, 0);
    check("midrst_stall_m", bus.stall_m, 0);
    check("midrst_err", bus.err, 0);
    check("midrst_state", dut.state, IDLE);
    bus.dreq = 0;
    no_ack = 0;
    @(negedge clk);
    reset = 1'b0;

    // Single transactions from the vector table
    for (int k = 0; k < 7; k++) begin
      ack_lat = vecs[k].lat;
      txn(vecs[k].is_d, vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].exp_rdata, 0, n);
      check("latency", n, vecs[k].exp_n);
      g = grant_log[$];
      check("grant_we_addr", {g.we, g.addr}, {vecs[k].is_d & vecs[k].we, vecs[k].addr});
      if (vecs[k].is_d) check("grant_wdata", g.wdata, vecs[k].wdata);
    end

    // Both requesters active: data first, then strict alternation
    ack_lat = 3;
    fork
      begin
        int m;
        txn(1, 1, 32'h100, 32'hDEAD_BEEF, 32'h0, 1, m);
        txn(1, 0, 32'h104, 32'h0, 32'hCAFE_F00D, 0, m);
      end
      begin
        int m;
        txn(0, 0, 32'h10, 32'h0, 32'h0000_0013, 1, m);
        txn(0, 0, 32'h14, 32'h0, 32'h0020_8133, 0, m);
      end
    join
    for (int k = 0; k < 4; k++) begin
      g = grant_log[grant_log.size() - 4 + k];
      check("fair_order", {g.we, g.addr}, order_exp[k]);
    end
    check("fair_store_wdata", grant_log[grant_log.size() - 4].wdata, 32'hDEAD_BEEF);

    // Fetch flush: ireq dropped in I_WAIT, ack two cycles later
    ack_lat = 3;
    bus.ireq = 1; bus.iaddr = 32'h20;
    @(negedge clk);
    check("flush_granted", bus.mem_req, 1);
    bus.ireq = 0;
    repeat (4) @(negedge clk);
    check("flush_addr", grant_log[$].addr, 32'h20);
    check("flush_state", dut.state, IDLE);
    check("flush_mem_req", bus.mem_req, 0);
    check("flush_irdata_kept", bus.irdata, 32'h0020_8133);
    check("flush_stall_f", bus.stall_f, 0);

    // Stray ack while idle
    stray_ack = 1;
    repeat (3) @(negedge clk);
    stray_ack = 0;
    check("stray_ack_state", dut.state, IDLE);
    check("stray_ack_outputs", {bus.mem_req, bus.ivalid, bus.dvalid}, 0);

`ifdef MEMARB_TIMEOUT_EN
    no_ack = 1; exp_err = 1;
    txn(1, 0, 32'h300, 32'h0, 32'h0, 0, n);
    check("timeout_latency", n, 5);
    no_ack = 0; exp_err = 0; ack_lat = 4;
    mem_img[32'h304] = 32'h0BAD_F00D;
    txn(1, 0, 32'h304, 32'h0, 32'h0BAD_F00D, 0, n);
    check("ack_at_limit_latency", n, 5);
`endif

    @(negedge clk);
    check("exp_i_drained", exp_i.size(), 0);
    check("exp_d_drained", exp_d.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
